bip_control_unit: RTL and testbench

- Control unit of the 16-bit accumulator processor (BIP-class): owns the program counter and decodes the current instruction word into datapath control strobes.
- Sits between program memory (o_PC addresses it, i_instr returns the word) and the accumulator/ALU/data-memory datapath.
- Instruction format: opcode = i_instr[15:11], operand = i_instr[10:0].

---
 rtl/bip_pkg.sv | 50 +++++
 rtl/bip_control_unit_if.sv | 33 +++
 rtl/bip_instr_decoder.sv | 59 +++++
 rtl/bip_control_unit.sv | 69 ++++++
 tb/tb_bip_control_unit.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/bip_pkg.sv
// Shared widths, opcode values, mux/ALU encodings and the decoded control word
// for the BIP-class accumulator processor.
package bip_pkg;

  localparam int PC_WIDTH      = 11;
  localparam int OPCODE_WIDTH  = 5;
  localparam int OPERAND_WIDTH = 11;
  localparam int INSTR_WIDTH   = OPCODE_WIDTH + OPERAND_WIDTH;

  localparam logic [OPCODE_WIDTH-1:0] OP_HLT  = 5'b00000;
  localparam logic [OPCODE_WIDTH-1:0] OP_STO  = 5'b00001;
  localparam logic [OPCODE_WIDTH-1:0] OP_LD   = 5'b00010;
  localparam logic [OPCODE_WIDTH-1:0] OP_LDI  = 5'b00011;
  localparam logic [OPCODE_WIDTH-1:0] OP_ADD  = 5'b00100;
  localparam logic [OPCODE_WIDTH-1:0] OP_ADDI = 5'b00101;
  localparam logic [OPCODE_WIDTH-1:0] OP_SUB  = 5'b00110;
  localparam logic [OPCODE_WIDTH-1:0] OP_SUBI = 5'b00111;

  localparam logic [1:0] SELA_MEM = 2'b00;
  localparam logic [1:0] SELA_IMM = 2'b01;
  localparam logic [1:0] SELA_ALU = 2'b10;

  localparam logic SELB_MEM = 1'b0;
  localparam logic SELB_IMM = 1'b1;

  localparam logic ALU_ADD = 1'b0;
  localparam logic ALU_SUB = 1'b1;

  typedef struct packed {
    logic [1:0] sel_a;
    logic       sel_b;
    logic       wr_acc;
    logic       alu_op;
    logic       wr_ram;
    logic       rd_ram;
    logic       wr_pc;
  } ctrl_t;

  // Everything idle but the PC advancing: the behaviour of every unassigned opcode.
  localparam ctrl_t CTRL_NOP = '{
    sel_a:  SELA_MEM,
    sel_b:  SELB_MEM,
    wr_acc: 1'b0,
    alu_op: ALU_ADD,
    wr_ram: 1'b0,
    rd_ram: 1'b0,
    wr_pc:  1'b1
  };

endpackage

// File: rtl/bip_control_unit_if.sv
// Program-memory / datapath bundle seen by the BIP control unit.
// No valid/ready: every signal is meaningful on every cycle; i_instr is the word
// addressed by o_PC in that same cycle, and the outputs are consumed every cycle.
interface bip_control_unit_if #(
  parameter int PC_WIDTH      = bip_pkg::PC_WIDTH,
  parameter int INSTR_WIDTH   = bip_pkg::INSTR_WIDTH,
  parameter int OPERAND_WIDTH = bip_pkg::OPERAND_WIDTH
);

  logic [INSTR_WIDTH-1:0]   i_instr;
  logic [PC_WIDTH-1:0]      o_PC;
  logic [OPERAND_WIDTH-1:0] o_signal;
  logic [1:0]               o_selA;
  logic                     o_selB;
  logic                     o_WrAcc;
  logic                     o_OP;
  logic                     o_WrRam;
  logic                     o_RdRam;
  logic                     dbg_halted;

  modport master (
    input  i_instr,
    output o_PC, o_signal, o_selA, o_selB, o_WrAcc, o_OP, o_WrRam, o_RdRam,
    output dbg_halted
  );

  modport slave (
    output i_instr,
    input  o_PC, o_signal, o_selA, o_selB, o_WrAcc, o_OP, o_WrRam, o_RdRam,
    input  dbg_halted
  );

endinterface

// File: rtl/bip_instr_decoder.sv
// Purely combinational opcode -> control word decode for the BIP control unit.
module bip_instr_decoder
  import bip_pkg::*;
(
  input  logic [OPCODE_WIDTH-1:0] opcode,
  output ctrl_t                   ctrl
);

  always_comb begin
    ctrl = CTRL_NOP;
    case (opcode)
      OP_HLT: begin
        ctrl.wr_pc = 1'b0;
      end
      OP_STO: begin
        ctrl.wr_ram = 1'b1;
      end
      OP_LD: begin
        ctrl.sel_a  = SELA_MEM;
        ctrl.wr_acc = 1'b1;
        ctrl.rd_ram = 1'b1;
      end
      OP_LDI: begin
        ctrl.sel_a  = SELA_IMM;
        ctrl.wr_acc = 1'b1;
      end
      OP_ADD: begin
        ctrl.sel_a  = SELA_ALU;
        ctrl.sel_b  = SELB_MEM;
        ctrl.wr_acc = 1'b1;
        ctrl.alu_op = ALU_ADD;
        ctrl.rd_ram = 1'b1;
      end
      OP_ADDI: begin
        ctrl.sel_a  = SELA_ALU;
        ctrl.sel_b  = SELB_IMM;
        ctrl.wr_acc = 1'b1;
        ctrl.alu_op = ALU_ADD;
      end
      OP_SUB: begin
        ctrl.sel_a  = SELA_ALU;
        ctrl.sel_b  = SELB_MEM;
        ctrl.wr_acc = 1'b1;
        ctrl.alu_op = ALU_SUB;
        ctrl.rd_ram = 1'b1;
      end
      OP_SUBI: begin
        ctrl.sel_a  = SELA_ALU;
        ctrl.sel_b  = SELB_IMM;
        ctrl.wr_acc = 1'b1;
        ctrl.alu_op = ALU_SUB;
      end
      default: begin
        ctrl = CTRL_NOP;
      end
    endcase
  end

endmodule

// File: rtl/bip_control_unit.sv
// BIP control unit: program counter, instruction decode and reset gating of strobes.
// Optional sticky halt flag is enabled by defining BIP_CTRL_STICKY_HALT_EN.
module bip_control_unit #(
  parameter int PC_WIDTH      = bip_pkg::PC_WIDTH,
  parameter int OPCODE_WIDTH  = bip_pkg::OPCODE_WIDTH,
  parameter int OPERAND_WIDTH = bip_pkg::OPERAND_WIDTH,
  parameter int INSTR_WIDTH   = bip_pkg::INSTR_WIDTH
) (
  input logic                i_clk,
  input logic                i_reset,
  bip_control_unit_if.master bus
);

  import bip_pkg::*;

  logic [OPCODE_WIDTH-1:0] opcode;
  ctrl_t                   dec;
  logic [PC_WIDTH-1:0]     pc_q;
  logic                    halted;
  logic                    pc_advance;
  logic                    strobe_en;

  assign opcode = bus.i_instr[INSTR_WIDTH-1 -: OPCODE_WIDTH];

  bip_instr_decoder u_decoder (
    .opcode (opcode),
    .ctrl   (dec)
  );

`ifdef BIP_CTRL_STICKY_HALT_EN
  // Once a HLT has been clocked in, only reset lets the program run again.
  logic halt_q;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      halt_q <= 1'b0;
    end else if (opcode == OP_HLT) begin
      halt_q <= 1'b1;
    end
  end

  assign halted = halt_q;
`else
  assign halted = 1'b0;
`endif

  assign pc_advance = dec.wr_pc & ~halted;
  assign strobe_en  = i_reset & ~halted;

  // Natural 11-bit overflow gives the 0x7FF -> 0x000 wrap.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      pc_q <= '0;
    end else if (pc_advance) begin
      pc_q <= pc_q + PC_WIDTH'(1);
    end
  end

  assign bus.o_PC       = pc_q;
  assign bus.o_signal   = bus.i_instr[OPERAND_WIDTH-1:0];
  assign bus.o_selA     = dec.sel_a;
  assign bus.o_selB     = dec.sel_b;
  assign bus.o_OP       = dec.alu_op;
  assign bus.o_WrAcc    = dec.wr_acc & strobe_en;
  assign bus.o_WrRam    = dec.wr_ram & strobe_en;
  assign bus.o_RdRam    = dec.rd_ram & strobe_en;
  assign bus.dbg_halted = halted;

endmodule

// File: tb/tb_bip_control_unit.sv
// Directed bench for bip_control_unit: table-driven reference model checked every
// cycle, plus literal expectations at chosen points of the program.
module tb_bip_control_unit;

  logic i_clk = 1'b0;
  logic i_reset;

  bip_control_unit_if bus ();

  bip_control_unit dut (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .bus     (bus)
  );

  // ---------------- clock / reset ----------------
  always #5 i_clk = ~i_clk;

  // ---------------- scoreboard state ----------------
  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [10:0] pc;
    logic [1:0]  sel_a;
    logic        sel_b;
    logic        wr_acc;
    logic        op;
    logic        wr_ram;
    logic        rd_ram;
    logic [10:0] sig;
  } exp_t;

  // Rows are opcodes 0..7, bits {selA[1:0], selB, WrAcc, OP, WrRam, RdRam}.
  localparam logic [6:0] CTRL_TBL [8] = '{
    7'b00_0_0_0_0_0,  // HLT
    7'b00_0_0_0_1_0,  // STO
    7'b00_0_1_0_0_1,  // LD
    7'b01_0_1_0_0_0,  // LDI
    7'b10_0_1_0_0_1,  // ADD
    7'b10_1_1_0_0_0,  // ADDI
    7'b10_0_1_1_0_1,  // SUB
    7'b10_1_1_1_0_0   // SUBI
  };

  int unsigned model_pc   = 0;
  bit          model_halt = 1'b0;
  bit          chk_en     = 1'b0;
  bit          pin_en     = 1'b0;
  exp_t        pin_exp;

  function automatic exp_t model_exp(input logic [15:0] instr, input logic rst_n,
                                     input int unsigned pc, input bit halt);
    exp_t       e;
    logic [6:0] c;
    int         op;
    op = int'(instr[15:11]);
    c  = (op < 8) ? CTRL_TBL[op] : 7'b0;
    e.sel_a  = c[6:5];
    e.sel_b  = c[4];
    e.wr_acc = c[3];
    e.op     = c[2];
    e.wr_ram = c[1];
    e.rd_ram = c[0];
    if (!rst_n || halt) begin
      e.wr_acc = 1'b0;
      e.wr_ram = 1'b0;
      e.rd_ram = 1'b0;
    end
    e.pc  = rst_n ? 11'(pc) : 11'd0;
    e.sig = instr[10:0];
    return e;
  endfunction

  // Model state advances on the same edge as the design.
  always @(posedge i_clk) begin
    bit stop;
    if (!i_reset) begin
      model_pc   = 0;
      model_halt = 1'b0;
    end else if (!$isunknown(bus.i_instr)) begin
      stop = model_halt || (bus.i_instr[15:11] == 5'd0);
`ifdef BIP_CTRL_STICKY_HALT_EN
      if (bus.i_instr[15:11] == 5'd0) model_halt = 1'b1;
`endif
      if (!stop) model_pc = (model_pc + 1) % 2048;
    end
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- compare process ----------------
  always @(negedge i_clk) begin
    exp_t e;
    if (!$isunknown(bus.i_instr)) begin
      e = model_exp(bus.i_instr, i_reset, model_pc, model_halt);
      if (chk_en) begin
        check("pc",     16'(bus.o_PC),       16'(e.pc));
        check("signal", 16'(bus.o_signal),   16'(e.sig));
        check("selA",   16'(bus.o_selA),     16'(e.sel_a));
        check("selB",   16'(bus.o_selB),     16'(e.sel_b));
        check("WrAcc",  16'(bus.o_WrAcc),    16'(e.wr_acc));
        check("OP",     16'(bus.o_OP),       16'(e.op));
        check("WrRam",  16'(bus.o_WrRam),    16'(e.wr_ram));
        check("RdRam",  16'(bus.o_RdRam),    16'(e.rd_ram));
        check("halted", 16'(bus.dbg_halted), 16'(i_reset && model_halt));
      end
      if (pin_en) begin
        check("pin_pc",     16'(bus.o_PC),     16'(pin_exp.pc));
        check("pin_signal", 16'(bus.o_signal), 16'(pin_exp.sig));
        check("pin_ctrl",
              16'({bus.o_selA, bus.o_selB, bus.o_WrAcc, bus.o_OP, bus.o_WrRam, bus.o_RdRam}),
              16'({pin_exp.sel_a, pin_exp.sel_b, pin_exp.wr_acc, pin_exp.op,
                   pin_exp.wr_ram, pin_exp.rd_ram}));
        check("model_vs_pin", 16'({e.pc, e.wr_acc, e.wr_ram, e.rd_ram}),
              16'({pin_exp.pc, pin_exp.wr_acc, pin_exp.wr_ram, pin_exp.rd_ram}));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic run(input logic [15:0] instr, input int n);
    bus.i_instr = instr;
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  task automatic pin(input logic [10:0] pc, input logic [1:0] sa, input logic sb,
                     input logic wa, input logic op, input logic wr, input logic rr,
                     input logic [10:0] sig);
    pin_exp = {pc, sa, sb, wa, op, wr, rr, sig};
    pin_en  = 1'b1;
    @(negedge i_clk);
    #1;
    pin_en  = 1'b0;
  endtask

  // ---------------- directed program ----------------
  initial begin
    i_reset     = 1'b0;
    bus.i_instr = 16'h1805;
    chk_en      = 1'b1;

    // Reset held: PC 0, strobes gated, decode still visible.
    run(16'h1805, 2);
    pin(11'd0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 11'd5);
    i_reset = 1'b1;
    run(16'h1805, 1);
    pin(11'd1, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 11'd5);

    run(16'h1800, 2);  // LDI 0
    pin(11'd3, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 11'd0);
    run(16'h2805, 1);  // ADDI 5
    pin(11'd4, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 11'd5);
    run(16'h3805, 1);  // SUBI 5
    pin(11'd5, 2'b10, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 11'd5);
    run(16'h0801, 1);  // STO 1
    pin(11'd6, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 11'd1);
    run(16'h1008, 1);  // LD 8
    pin(11'd7, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 11'd8);
    run(16'h2003, 1);  // ADD 3
    pin(11'd8, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 11'd3);
    run(16'h3003, 1);  // SUB 3
    pin(11'd9, 2'b10, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 11'd3);

    run(16'h0000, 3);  // HLT for three edges
    pin(11'd9, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 11'd0);
    run(16'h1807, 2);  // LDI 7 after halt
`ifdef BIP_CTRL_STICKY_HALT_EN
    pin(11'd9, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 11'd7);
`else
    pin(11'd11, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 11'd7);
`endif

    // Asynchronous reset: PC reads 0 before any further clock edge.
    @(posedge i_clk);
    #1;
    i_reset = 1'b0;
    pin(11'd0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 11'd7);

    // Undefined instruction while in reset, then a clean restart from 0.
    run(16'hxxxx, 2);
    bus.i_instr = 16'h1000;
    i_reset     = 1'b1;
    run(16'h1000, 1);  // LD 0
    pin(11'd1, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 11'd0);
    run(16'hFFFF, 1);  // top opcode is a NOP
    pin(11'd2, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 11'h7FF);

    // NOP run through the full address space and the wrap.
    i_reset = 1'b0;
    run(16'h4000, 1);
    i_reset = 1'b1;
    run(16'h4000, 2047);
    pin(11'h7FF, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 11'd0);
    run(16'h4000, 1);
    pin(11'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 11'd0);

    chk_en = 1'b0;
    @(negedge i_clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
